// File: rtl/zc_phase_gen.sv
// Zadoff-Chu phase generator for PUSCH DMRS base sequences.
// It latches the sequence parameters when a start request is accepted.
// It then produces one normalized phase word per sample n = 0..Mzc-1,
// using an incremental quadratic recursion with cyclic extension past Nzc.
// The output is a single-entry register that obeys valid/ready backpressure.
//
// state | meaning
// IDLE  | waiting for a start request with a non-zero length
// RUN   | generating samples until the last one is accepted
module zc_phase_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [9:0]  Mzc,
  input  logic [9:0]  Nzc,
  input  logic [29:0] Nzc_rec,
  input  logic [9:0]  q,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_phase,
  output logic [9:0]  out_n,
  output logic        out_last
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [9:0]  mzc_r, nzc_r, qr_r;
  logic [29:0] rec_r;
  logic [9:0]  m_r, a_r, d_r, n_r;
  logic        last_loaded;

  logic        accept_start, load, accept_last, is_last, wrap;
  logic [10:0] a_sum, d_sum;
  logic [9:0]  a_step, d_step, q_red;
  logic [33:0] product;
  logic [15:0] phase_nxt;

  // Handshake decode and one step of the phase recursion
  always_comb begin
    accept_start = (state == IDLE) && start && (Mzc != 10'd0);
    load         = (state == RUN) && !last_loaded && (!out_valid || out_ready);
    accept_last  = out_valid && out_ready && out_last;
    is_last      = (n_r == 10'(mzc_r - 10'd1));
    wrap         = ({1'b0, m_r} + 11'd1) == {1'b0, nzc_r};
    q_red        = (q >= Nzc) ? 10'(q - Nzc) : q;
    a_sum        = {1'b0, a_r} + {1'b0, d_r};
    d_sum        = {1'b0, d_r} + {1'b0, qr_r};
    a_step       = (a_sum >= {1'b0, nzc_r}) ? 10'(a_sum - {1'b0, nzc_r}) : a_sum[9:0];
    d_step       = (d_sum >= {1'b0, nzc_r}) ? 10'(d_sum - {1'b0, nzc_r}) : d_sum[9:0];
    // Only bits up to 33 matter; a < Nzc keeps the phase inside 16 bits.
    product      = 34'(a_r) * 34'(rec_r);
    phase_nxt    = 16'(product >> 18);
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept_start) state_nxt = RUN;
      RUN:  if (accept_last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  // State, parameter latch, recursion and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mzc_r       <= '0;
      nzc_r       <= '0;
      rec_r       <= '0;
      qr_r        <= '0;
      m_r         <= '0;
      a_r         <= '0;
      d_r         <= '0;
      n_r         <= '0;
      last_loaded <= 1'b0;
      out_valid   <= 1'b0;
      out_phase   <= '0;
      out_n       <= '0;
      out_last    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept_start) begin
        mzc_r       <= Mzc;
        nzc_r       <= Nzc;
        rec_r       <= Nzc_rec;
        qr_r        <= q_red;
        m_r         <= '0;
        a_r         <= '0;
        d_r         <= q_red;
        n_r         <= '0;
        last_loaded <= 1'b0;
      end else if (load) begin
        out_valid   <= 1'b1;
        out_phase   <= phase_nxt;
        out_n       <= n_r;
        out_last    <= is_last;
        last_loaded <= is_last;
        n_r         <= 10'(n_r + 10'd1);
        if (wrap) begin
          m_r <= '0;
          a_r <= '0;
          d_r <= qr_r;
        end else begin
          m_r <= 10'(m_r + 10'd1);
          a_r <= a_step;
          d_r <= d_step;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule
